reg_file_clr: RTL and testbench
===============================

Name: reg_file_clr

Overview:
Parametrised successor to the processor's 2-read/1-write register file. Adds:
- synchronous reset with a sequential clear engine (one entry per cycle) and a busy flag
- optional hard-wired zero register
- optional write-to-read bypass
- per-byte write enables

Sits in the decode stage. It feeds the ALU operand muxes and receives write-back data.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; starts the clear sequence
reg_write  in  1  write request
write_be  in  DATA_W/8  byte enables for the write; bit i covers byte i
write_reg  in  ADDR_W  write address
write_data  in  DATA_W  write data
read_reg1  in  ADDR_W  read address, port 1
read_reg2  in  ADDR_W  read address, port 2
read_data1  out  DATA_W  read data, port 1 (combinational)
read_data2  out  DATA_W  read data, port 2 (combinational)
busy  out  1  high while the clear is in progress; writes are ignored and reads return 0
write_dropped  out  1  registered; pulses 1 cycle after a reg_write is ignored because busy was high

Behaviour:
- One clock, clk. Reset is synchronous and active-high. Everything is evaluated only at the clk rising edge.
- State machine has two states, CLEAR and IDLE, plus an ADDR_W-bit index counter clr_idx.
- Reset edge:
  - state <= CLEAR, clr_idx <= 0, busy <= 1, write_dropped <= 0.
  - Storage is not modified on reset edges.
  - Holding reset high keeps the block in CLEAR with clr_idx = 0.
- CLEAR (reset low), at each edge:
  - mem[clr_idx] <= 0, clr_idx <= clr_idx + 1.
  - When clr_idx == DEPTH-1 is written, state <= IDLE and busy <= 0.
  - busy is therefore high for exactly DEPTH cycles after reset deasserts.
- Reset asserted mid-clear restarts the sequence from index 0.
- While busy = 1:
  - read_data1/2 = 0.
  - reg_write is ignored, and write_dropped <= reg_write on the next edge.
- IDLE write:
  - If reg_write=1, each byte i of mem[write_reg] with write_be[i]=1 takes write_data byte i. Other bytes are kept.
  - write_be = 0 means no change.
  - If ZERO_REG=1 and write_reg == 0, the write is discarded silently; write_dropped stays 0.
- IDLE read, per port independently:
  - If ZERO_REG=1 and the address is 0, the output is 0.
  - Else, if BYPASS=1 and reg_write=1 and write_reg == the read address: each byte with write_be[i]=1 comes from write_data; the other bytes come from mem.
  - Else the output is mem[addr].
- Both ports may read the same address. Both ports may hit the bypass in the same cycle.
- With BYPASS=0, new data is visible on the read ports the cycle after the write edge.
- Latency:
  - Reads are 0 cycles (combinational).
  - Writes take effect at the edge where reg_write=1.
- Storage has no other reset. After the clear completes, all entries read 0.

Test Plan:
1. Pulse reset 1 cycle, defaults -> busy high for exactly 32 cycles; afterwards reads of regs 1..31 = 0x00000000; read_reg1=0 -> 0.
2. IDLE: write reg 5 = 0xDEADBEEF with be=4'hF, then write_be=4'b0010 data 0x00001200 -> reg 5 reads 0xDEAD12EF.
3. BYPASS=1: reg_write=1, write_reg=7, data 0xA5A5A5A5, be=4'hF, read_reg1=read_reg2=7 in the same cycle -> both outputs 0xA5A5A5A5 before the edge. With BYPASS=0 the same stimulus -> old value (0) until after the edge.
4. Write 0xFFFFFFFF to reg 0 with ZERO_REG=1 -> read_data1 (reg 0) = 0, write_dropped = 0. With ZERO_REG=0 -> reg 0 reads 0xFFFFFFFF.
5. Assert reset again when clr_idx=10, after reg 20 had been written 0x12345678 -> busy stays high 32 more cycles after release; reg 20 reads 0; a reg_write during busy -> write_dropped=1 the next cycle and no storage change.
6. ADDR_W=3, DATA_W=16 -> busy high for 8 cycles; write reg 7 = 0xBEEF, be=2'b11 -> reads 0xBEEF; index wrap leaves no stale clear activity in IDLE.

Source files
------------

// File: rtl/reg_file_clr.sv
// 2-read/1-write register file with a sequential clear engine, optional zero register,
// optional write-to-read bypass and per-byte write enables.
module reg_file_clr #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [DATA_W/8-1:0]   write_be,
  input  logic [ADDR_W-1:0]     write_reg,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [ADDR_W-1:0]     read_reg1,
  input  logic [ADDR_W-1:0]     read_reg2,
  output logic [DATA_W-1:0]     read_data1,
  output logic [DATA_W-1:0]     read_data2,
  output logic                  busy,
  output logic                  write_dropped
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned NumBytes = DATA_W / 8;

  typedef enum logic {StClear, StIdle} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                write_dropped_q, write_dropped_d;
  logic [DATA_W-1:0]   mem_q [Depth];
  logic [DATA_W-1:0]   mem_d [Depth];

  logic [ADDR_W-1:0]   raddr [2];
  logic [DATA_W-1:0]   rdata [2];

  assign busy          = (state_q == StClear);
  assign write_dropped = write_dropped_q;

  always_comb begin
    state_d         = state_q;
    clr_idx_d       = clr_idx_q;
    write_dropped_d = 1'b0;
    mem_d           = mem_q;
    case (state_q)
      StClear: begin
        mem_d[clr_idx_q] = '0;
        clr_idx_d        = clr_idx_q + 1'b1;
        write_dropped_d  = reg_write;
        if (&clr_idx_q) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        // Writes to the hard-wired zero entry vanish without flagging a drop.
        if (reg_write && !(ZERO_REG && (write_reg == '0))) begin
          for (int b = 0; b < NumBytes; b++) begin
            if (write_be[b]) begin
              mem_d[write_reg][8*b +: 8] = write_data[8*b +: 8];
            end
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StClear;
      clr_idx_q       <= '0;
      write_dropped_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      clr_idx_q       <= clr_idx_d;
      write_dropped_q <= write_dropped_d;
    end
  end

  // Storage keeps its contents across reset edges; only the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  assign raddr[0] = read_reg1;
  assign raddr[1] = read_reg2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = mem_q[raddr[p]];
      if (BYPASS && reg_write && (write_reg == raddr[p])) begin
        for (int b = 0; b < NumBytes; b++) begin
          if (write_be[b]) begin
            rdata[p][8*b +: 8] = write_data[8*b +: 8];
          end
        end
      end
      if (busy || (ZERO_REG && (raddr[p] == '0))) begin
        rdata[p] = '0;
      end
    end
  end

  assign read_data1 = rdata[0];
  assign read_data2 = rdata[1];

endmodule

// File: tb/tb_reg_file_clr.sv
// Directed bench for reg_file_clr: default, no-bypass/no-zero-reg and narrow configurations.
module tb_reg_file_clr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_write = 1'b0;
  logic [3:0]  write_be = '0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_reg1 = '0;
  logic [4:0]  read_reg2 = '0;
  logic [31:0] rd1_d, rd2_d, rd1_a, rd2_a;
  logic        busy_d, busy_a, wd_d, wd_a;

  logic        s_we = 1'b0;
  logic [1:0]  s_be = '0;
  logic [2:0]  s_wreg = '0;
  logic [15:0] s_wdata = '0;
  logic [2:0]  s_r1 = '0;
  logic [2:0]  s_r2 = '0;
  logic [15:0] s_rd1, s_rd2;
  logic        s_busy, s_wd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_clr u_def (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_be(write_be),
    .write_reg(write_reg), .write_data(write_data), .read_reg1(read_reg1),
    .read_reg2(read_reg2), .read_data1(rd1_d), .read_data2(rd2_d), .busy(busy_d),
    .write_dropped(wd_d)
  );

  reg_file_clr #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_alt (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_be(write_be),
    .write_reg(write_reg), .write_data(write_data), .read_reg1(read_reg1),
    .read_reg2(read_reg2), .read_data1(rd1_a), .read_data2(rd2_a), .busy(busy_a),
    .write_dropped(wd_a)
  );

  reg_file_clr #(.DATA_W(16), .ADDR_W(3)) u_small (
    .clk(clk), .reset(reset), .reg_write(s_we), .write_be(s_be), .write_reg(s_wreg),
    .write_data(s_wdata), .read_reg1(s_r1), .read_reg2(s_r2), .read_data1(s_rd1),
    .read_data2(s_rd2), .busy(s_busy), .write_dropped(s_wd)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [4:0]  wreg;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1d;
    logic [31:0] e2d;
    logic [31:0] e1a;
    logic [31:0] e2a;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge right after the reset edge; counts busy cycles.
  task automatic clear_wait(input int inject_at, input bit small_test, output int n);
    int ns;
    n  = 0;
    ns = 0;
    while (busy_d === 1'b1 && n < 100) begin
      ns += int'(s_busy);
      if (inject_at >= 0 && n == inject_at) begin
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 32'hCAFEF00D;
        write_be   = 4'hF;
        read_reg1  = 5'd3;
        read_reg2  = 5'd5;
        #1;
        chk("busy_read1_def", rd1_d, 32'h0);
        chk("busy_read2_alt", rd2_a, 32'h0);
      end
      if (inject_at >= 0 && n == inject_at + 1) begin
        chk("dropped_def", 32'(wd_d), 32'h1);
        chk("dropped_alt", 32'(wd_a), 32'h1);
        reg_write = 1'b0;
      end
      if (inject_at >= 0 && n == inject_at + 2) begin
        chk("dropped_clear_def", 32'(wd_d), 32'h0);
      end
      if (small_test && n == 9) begin
        s_r1 = 3'd3;
        #1;
        chk("small_cleared", 32'(s_rd1), 32'h0);
      end
      if (small_test && n == 10) begin
        s_we = 1'b1; s_be = 2'b11; s_wreg = 3'd7; s_wdata = 16'hBEEF;
        s_r1 = 3'd7; s_r2 = 3'd0;
        #1;
        chk("small_bypass", 32'(s_rd1), 32'h0000BEEF);
        chk("small_zero", 32'(s_rd2), 32'h0);
      end
      if (small_test && n == 11) begin
        s_we = 1'b0;
        #1;
        chk("small_written", 32'(s_rd1), 32'h0000BEEF);
      end
      n++;
      @(negedge clk);
    end
    chk("busy_alt_done", 32'(busy_a), 32'h0);
    if (small_test) begin
      chk("small_busy_cycles", 32'(ns), 32'd8);
      chk("small_busy_done", 32'(s_busy), 32'h0);
      chk("small_kept", 32'(s_rd1), 32'h0000BEEF);
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, 4'hF, 5'd5,  32'hDEADBEEF, 5'd5,  5'd1,
                 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 4'h2, 5'd5,  32'h00001200, 5'd5,  5'd5,
                 32'hDEAD12EF, 32'hDEAD12EF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 4'h0, 5'd0,  32'h0,        5'd5,  5'd0,
                 32'hDEAD12EF, 32'h0, 32'hDEAD12EF, 32'h0};
    vecs[3]  = '{1'b1, 4'hF, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,
                 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 4'h0, 5'd0,  32'h0,        5'd7,  5'd7,
                 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[5]  = '{1'b1, 4'hF, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,
                 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 4'h0, 5'd0,  32'h0,        5'd0,  5'd5,
                 32'h0, 32'hDEAD12EF, 32'hFFFFFFFF, 32'hDEAD12EF};
    vecs[7]  = '{1'b1, 4'h0, 5'd5,  32'h11111111, 5'd5,  5'd7,
                 32'hDEAD12EF, 32'hA5A5A5A5, 32'hDEAD12EF, 32'hA5A5A5A5};
    vecs[8]  = '{1'b0, 4'h0, 5'd0,  32'h0,        5'd5,  5'd7,
                 32'hDEAD12EF, 32'hA5A5A5A5, 32'hDEAD12EF, 32'hA5A5A5A5};
    vecs[9]  = '{1'b1, 4'h9, 5'd20, 32'h12345678, 5'd20, 5'd20,
                 32'h12000078, 32'h12000078, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 4'h0, 5'd0,  32'h0,        5'd20, 5'd31,
                 32'h12000078, 32'h0, 32'h12000078, 32'h0};
    vecs[11] = '{1'b1, 4'hF, 5'd20, 32'h12345678, 5'd20, 5'd5,
                 32'h12345678, 32'hDEAD12EF, 32'h12000078, 32'hDEAD12EF};
    vecs[12] = '{1'b0, 4'h0, 5'd0,  32'h0,        5'd20, 5'd0,
                 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF};

    // One reset edge at the first posedge, then the full clear.
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 32'(busy_d), 32'h1);
    chk("reset_dropped", 32'(wd_d), 32'h0);
    clear_wait(-1, 1'b1, n);
    chk("busy_cycles", 32'(n), 32'd32);

    for (int r = 0; r < 32; r++) begin
      read_reg1 = 5'(r);
      read_reg2 = 5'(31 - r);
      #1;
      chk("cleared_def", rd1_d, 32'h0);
      chk("cleared_alt", rd2_a, 32'h0);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      reg_write  = vecs[i].we;
      write_be   = vecs[i].be;
      write_reg  = vecs[i].wreg;
      write_data = vecs[i].wd;
      read_reg1  = vecs[i].r1;
      read_reg2  = vecs[i].r2;
      #1;
      chk($sformatf("v%0d_rd1_def", i), rd1_d, vecs[i].e1d);
      chk($sformatf("v%0d_rd2_def", i), rd2_d, vecs[i].e2d);
      chk($sformatf("v%0d_rd1_alt", i), rd1_a, vecs[i].e1a);
      chk($sformatf("v%0d_rd2_alt", i), rd2_a, vecs[i].e2a);
      chk($sformatf("v%0d_dropped", i), 32'({wd_d, wd_a}), 32'h0);
    end

    // Restart the clear when clr_idx reaches 10.
    @(negedge clk);
    reg_write = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("midclear_busy", 32'(busy_d), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_wait(20, 1'b0, n);
    chk("restart_busy_cycles", 32'(n), 32'd32);

    read_reg1 = 5'd20;
    read_reg2 = 5'd3;
    #1;
    chk("restart_r20_def", rd1_d, 32'h0);
    chk("restart_r3_def", rd2_d, 32'h0);
    chk("restart_r20_alt", rd1_a, 32'h0);
    chk("restart_r3_alt", rd2_a, 32'h0);
    read_reg1 = 5'd5;
    read_reg2 = 5'd0;
    #1;
    chk("restart_r5_def", rd1_d, 32'h0);
    chk("restart_r0_alt", rd2_a, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
